// File: rtl/dct_qz_pkg.sv
// Shared constants, lookup tables and FSM state type for the DCT quantize/zigzag stage.
package dct_qz_pkg;

  localparam int unsigned COEF_W  = 12;
  localparam int unsigned N_COEF  = 16;
  localparam int unsigned BLK_W   = COEF_W * N_COEF;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned SHIFT_W = 3;

  // Raster index k for each zigzag beat; beat i lives at bits [4i+3:4i].
  localparam logic [N_COEF*IDX_W-1:0] ZIGZAG_TBL = {
    4'd15, 4'd14, 4'd11, 4'd7, 4'd10, 4'd13, 4'd12, 4'd9,
    4'd6,  4'd3,  4'd2,  4'd5, 4'd8,  4'd4,  4'd1,  4'd0
  };

  // Base shift 1 + ((row+col)>>1) for raster index k at bits [3k+2:3k].
  localparam logic [N_COEF*SHIFT_W-1:0] BASE_SHIFT_TBL = {
    3'd4, 3'd3, 3'd3, 3'd2,
    3'd3, 3'd3, 3'd2, 3'd2,
    3'd3, 3'd2, 3'd2, 3'd1,
    3'd2, 3'd2, 3'd1, 3'd1
  };

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  function automatic logic [IDX_W-1:0] zigzag_k(input logic [IDX_W-1:0] beat);
    return ZIGZAG_TBL[beat*IDX_W +: IDX_W];
  endfunction

  function automatic logic [SHIFT_W-1:0] base_shift(input logic [IDX_W-1:0] k);
    return BASE_SHIFT_TBL[k*SHIFT_W +: SHIFT_W];
  endfunction

endpackage

// File: rtl/qz_quantizer.sv
// Combinational quantizer: q = sign(x) * (|x| >> s), with optional half-up rounding of the
// magnitude when QZ_ROUND_EN is defined. s is expected in 1..7.
module qz_quantizer
  import dct_qz_pkg::*;
(
  input  logic signed [COEF_W-1:0]  x_i,
  input  logic        [SHIFT_W-1:0] s_i,
  output logic signed [COEF_W-1:0]  q_o
);

  localparam int unsigned MAG_W = COEF_W + 1;

  logic             neg;
  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] mag_adj;
  logic [MAG_W-1:0] res;

  // Work on a 13-bit magnitude so -2048 has a representable absolute value.
  always_comb begin
    neg = x_i[COEF_W-1];
    mag = neg ? (MAG_W'(0) - {x_i[COEF_W-1], x_i}) : {1'b0, x_i};
`ifdef QZ_ROUND_EN
    mag_adj = mag + (MAG_W'(1) << (s_i - SHIFT_W'(1)));
`else
    mag_adj = mag;
`endif
    res = mag_adj >> s_i;
    q_o = COEF_W'(neg ? (MAG_W'(0) - res) : res);
  end

endmodule

// File: rtl/dct_quant_zigzag.sv
// Ping-pong block buffer behind the 4x4 DCT: captures 192-bit coefficient blocks, quantizes
// each coefficient and streams them out in zigzag order under valid/ready backpressure.
// Rounding mode selected by the QZ_ROUND_EN macro (defined: round half away from zero,
// undefined: truncate toward zero).
module dct_quant_zigzag
  import dct_qz_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [BLK_W-1:0]  X_k_in,
  input  logic              in_valid,
  input  logic [1:0]        qp,
  output logic [COEF_W-1:0] coef_out,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              overflow
);

  // Buffer storage and bookkeeping.
  logic [BLK_W-1:0] slot_q    [2];
  logic [1:0]       slot_qp_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             ovf_q;

  // Read side: beat_q is the next zigzag beat to be loaded from slot[rd_ptr_q].
  state_e             state_q;
  logic [IDX_W-1:0]   beat_q;
  logic [COEF_W-1:0]  coef_q;
  logic [IDX_W-1:0]   idx_q;
  logic               valid_q;
  logic               last_q;

  logic [BLK_W-1:0]   blk_rd;
  logic [IDX_W-1:0]   k_sel;
  logic [SHIFT_W-1:0] shift_sel;
  logic [COEF_W-1:0]  x_sel;
  logic [COEF_W-1:0]  q_sel;
  logic               adv;
  logic               load;
  logic               free;
  logic               cap;

  // Select the coefficient and shift for the next beat, and decide load/free/capture.
  always_comb begin
    blk_rd    = slot_q[rd_ptr_q];
    k_sel     = zigzag_k(beat_q);
    shift_sel = base_shift(k_sel) + SHIFT_W'(slot_qp_q[rd_ptr_q]);
    x_sel     = '0;
    for (int i = 0; i < int'(N_COEF); i++) begin
      if (k_sel == IDX_W'(i)) begin
        x_sel = blk_rd[i*COEF_W +: COEF_W];
      end
    end
    // The output register can take a new beat when empty or when its beat is being accepted.
    adv  = (state_q == StIdle) || out_ready;
    load = adv && (count_q != 2'd0);
    // The slot is released as soon as its last beat is copied into the output register.
    free = load && (beat_q == 4'd15);
    cap  = in_valid && ((count_q != 2'd2) || free);
  end

  // Occupancy next-state: capture and free on the same edge cancel out.
  always_comb begin
    count_d = count_q;
    case ({cap, free})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  qz_quantizer u_quant (
    .x_i (x_sel),
    .s_i (shift_sel),
    .q_o (q_sel)
  );

  // Slot payload needs no reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (cap) begin
      slot_q[wr_ptr_q]    <= X_k_in;
      slot_qp_q[wr_ptr_q] <= qp;
    end
  end

  // Write pointer, occupancy and sticky drop flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (cap) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (in_valid && !cap) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Output FSM with registered coefficient, index, valid and last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      rd_ptr_q <= 1'b0;
      coef_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      if (load) begin
        beat_q  <= beat_q + 4'd1;
        coef_q  <= q_sel;
        idx_q   <= k_sel;
        last_q  <= (beat_q == 4'd15);
        valid_q <= 1'b1;
        if (free) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
      case (state_q)
        StIdle: begin
          if (load) begin
            state_q <= StSend;
          end
        end
        StSend: begin
          // Current beat accepted and nothing left to send: drain to idle.
          if (out_ready && !load) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign coef_out  = coef_q;
  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Directed bench for dct_quant_zigzag: latency, rounding, zigzag order, backpressure,
// overflow drop and asynchronous reset abort.
module tb_dct_quant_zigzag;

  logic         clk;
  logic         rstn;
  logic [191:0] X_k_in;
  logic         in_valid;
  logic [1:0]   qp;
  logic [11:0]  coef_out;
  logic [3:0]   out_idx;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic         overflow;

  int n_vec  = 0;
  int n_fail = 0;

  int zz_idx [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  // X[k] = (k+1) << 7 at qp=0, listed in zigzag beat order; X[15] wraps to -2048.
  int ramp_q [16] = '{64, 128, 320, 288, 192, 96, 128, 224, 320, 416, 224, 176, 128, 192,
                      240, -128};
  int exp_coef [16];

`ifdef QZ_ROUND_EN
  localparam int NEG101_Q = -51;
  localparam int X1000_Q  = 8;
`else
  localparam int NEG101_Q = -50;
  localparam int X1000_Q  = 7;
`endif

  dct_quant_zigzag dut (
    .clk       (clk),
    .rstn      (rstn),
    .X_k_in    (X_k_in),
    .in_valid  (in_valid),
    .qp        (qp),
    .coef_out  (coef_out),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_single(input int beat, input int val);
    for (int i = 0; i < 16; i++) exp_coef[i] = 0;
    exp_coef[beat] = val;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 16; i++) exp_coef[i] = ramp_q[i];
  endtask

  function automatic logic [191:0] ramp_blk();
    logic [191:0] b;
    for (int k = 0; k < 16; k++) b[12*k +: 12] = 12'((k + 1) << 7);
    return b;
  endfunction

  // Entered with beat 0 visible (just after an edge). Leaves just after beat 15 is accepted.
  task automatic check_beats(input string tag, input int stall_at, input int stall_len);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_idx"}, out_idx, zz_idx[i]);
      chk({tag, "_coef"}, $signed(coef_out), exp_coef[i]);
      chk({tag, "_last"}, out_last, (i == 15) ? 1 : 0);
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int j = 0; j < stall_len; j++) begin
          @(posedge clk); #1;
          chk({tag, "_hold_valid"}, out_valid, 1);
          chk({tag, "_hold_idx"}, out_idx, zz_idx[i]);
          chk({tag, "_hold_coef"}, $signed(coef_out), exp_coef[i]);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [191:0] blk_a;
    logic [191:0] blk_b;
    logic [191:0] blk_dc;
    rstn      = 1'b0;
    X_k_in    = '0;
    in_valid  = 1'b0;
    qp        = 2'd0;
    out_ready = 1'b1;
    blk_dc        = '0;
    blk_dc[11:0]  = 12'd100;

    // Reset values while rstn is held low.
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_coef", coef_out, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Single DC block: latency E0 -> E1 and out_last only on beat 15.
    X_k_in = blk_dc; qp = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("dc_lat_e0", out_valid, 0);
    @(posedge clk); #1;
    set_single(0, 50);
    check_beats("dc", -1, 0);
    chk("dc_idle", out_valid, 0);

    // Back-to-back: negative rounding, then qp=3 at s=7; no bubble between blocks.
    blk_a = '0; blk_a[11:0] = 12'(-101);
    blk_b = '0; blk_b[191:180] = 12'd1000;
    X_k_in = blk_a; qp = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    X_k_in = blk_b; qp = 2'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    set_single(0, NEG101_Q);
    check_beats("neg", -1, 0);
    set_single(15, X1000_Q);
    check_beats("qp3", -1, 0);
    chk("b2b_idle", out_valid, 0);

    // Ramp block: full zigzag index and coefficient table.
    X_k_in = ramp_blk(); qp = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    set_ramp();
    check_beats("ramp", -1, 0);

    // Ramp block with out_ready low for 5 cycles at beat 6.
    X_k_in = ramp_blk(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_beats("stall", 6, 5);
    chk("stall_idle", out_valid, 0);

    // Three strobes on consecutive cycles with the consumer stalled: third is dropped.
    out_ready = 1'b0;
    X_k_in = ramp_blk(); qp = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    X_k_in = blk_dc;
    @(posedge clk); #1;
    chk("ovf_before", overflow, 0);
    X_k_in = blk_a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_hold_idx", out_idx, 0);
    chk("ovf_hold_coef", $signed(coef_out), 64);
    out_ready = 1'b1;
    set_ramp();
    check_beats("ovf_blk1", -1, 0);
    set_single(0, 50);
    check_beats("ovf_blk2", -1, 0);
    chk("ovf_drop_idle", out_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Asynchronous reset at beat 9 aborts the block.
    X_k_in = ramp_blk(); qp = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_idx", out_idx, 12);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_coef", coef_out, 0);
    chk("arst_idx", out_idx, 0);
    chk("arst_last", out_last, 0);
    chk("arst_ovf", overflow, 0);
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", out_valid, 0);
    X_k_in = blk_dc; qp = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    set_single(0, 50);
    check_beats("post_rst", -1, 0);
    chk("post_rst_done", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
